hazard_ctrl_unit: RTL

Parametrised successor to the pipeline's load-use stall logic.
- Generates PC/IF/ID/ID/EX write-enables and flushes for the five-stage core.
- Supports configurable load-use bubble count for multi-cycle data memory.
- Supports multi-cycle MUL/DIV occupancy of EX, taken-branch/jump flush, and a stall-cycle performance counter.
- Sits beside ID; driven by IF/ID and ID/EX pipeline-register fields and the EX branch resolver.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_lat_counter.sv | 34 +++
 rtl/hazard_ctrl_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared state encoding and control-vector constants for the
//          pipeline hazard controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int unsigned c_REG_ADDR_W = 5;

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MDU_BUSY   = 2'd2;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    localparam ctrl_t c_CTRL_RUN         = 6'b111000;
    localparam ctrl_t c_CTRL_BRANCH      = 6'b111110;
    localparam ctrl_t c_CTRL_MDU_HOLD    = 6'b000001;
    localparam ctrl_t c_CTRL_LOAD_BUBBLE = 6'b001010;
    localparam ctrl_t c_CTRL_RESET       = 6'b111111;

endpackage

`default_nettype wire

// File: rtl/hazard_lat_counter.sv
// ============================================================================
// Module : hazard_lat_counter
// Brief  : Loadable 4-bit down-counter with zero flag, shared by both stall
//          states of the hazard controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
// Module : hazard_ctrl_unit
// Brief  : Load-use / MUL-DIV / branch hazard controller for the five-stage
//          core, with a stall-cycle performance counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = c_REG_ADDR_W,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MDU_LAT    = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_mdu,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_uses_rs1,
    input  logic                  if_id_uses_rs2,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_cycles
);

    if ((LOAD_LAT < 1) || (LOAD_LAT > 15)) begin : g_bad_load_lat
        $error("hazard_ctrl_unit: LOAD_LAT must be in 1..15");
    end
    if ((MDU_LAT < 2) || (MDU_LAT > 15)) begin : g_bad_mdu_lat
        $error("hazard_ctrl_unit: MDU_LAT must be in 2..15");
    end

    // Reload values are one less than the extra cycles, since the entry
    // cycle itself already counts as the first bubble / hold.
    localparam logic [3:0] c_LOAD_RELOAD = 4'(LOAD_LAT - 2);
    localparam logic [3:0] c_MDU_RELOAD  = 4'(MDU_LAT - 2);
    localparam bit         c_LOAD_MULTI  = (LOAD_LAT > 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_hz;
    logic             w_cnt_load;
    logic [3:0]       w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    ctrl_t            w_ctrl;
    logic [CNT_W-1:0] r_stall_cycles;

    assign w_hz = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                   (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

    hazard_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = c_LOAD_RELOAD;
        w_cnt_dec      = 1'b0;
        case (r_state)
            RUN: begin
                if (!ex_branch_taken && id_ex_mdu) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_MDU_RELOAD;
                    w_next_state   = MDU_BUSY;
                end else if (!ex_branch_taken && w_hz && c_LOAD_MULTI) begin
                    w_cnt_load   = 1'b1;
                    w_next_state = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                if (w_cnt_zero) begin
                    w_next_state = RUN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (!w_cnt_zero) begin
                    w_cnt_dec = 1'b1;
                end else if (!ex_branch_taken && w_hz && c_LOAD_MULTI) begin
                    w_cnt_load   = 1'b1;
                    w_next_state = LOAD_STALL;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    // The MDU release cycle behaves like RUN with id_ex_mdu masked off.
    always_comb begin
        w_ctrl = c_CTRL_RUN;
        case (r_state)
            RUN: begin
                if (ex_branch_taken)   w_ctrl = c_CTRL_BRANCH;
                else if (id_ex_mdu)    w_ctrl = c_CTRL_MDU_HOLD;
                else if (w_hz)         w_ctrl = c_CTRL_LOAD_BUBBLE;
            end
            LOAD_STALL: w_ctrl = c_CTRL_LOAD_BUBBLE;
            MDU_BUSY: begin
                if (!w_cnt_zero)       w_ctrl = c_CTRL_MDU_HOLD;
                else if (ex_branch_taken) w_ctrl = c_CTRL_BRANCH;
                else if (w_hz)         w_ctrl = c_CTRL_LOAD_BUBBLE;
            end
            default: w_ctrl = c_CTRL_RUN;
        endcase
        if (rst) begin
            w_ctrl = c_CTRL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall_active) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign pc_write     = w_ctrl.pc_write;
    assign if_id_write  = w_ctrl.if_id_write;
    assign id_ex_write  = w_ctrl.id_ex_write;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_flush  = w_ctrl.id_ex_flush;
    assign ex_mem_flush = w_ctrl.ex_mem_flush;
    assign stall_active = ~w_ctrl.pc_write;
    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
